dili_center_stream: RTL and testbench
=====================================

// Module: dili_center_stream
// PURPOSE
//  Inverse of the freeze path: maps canonical coefficients in [0,Q) back to the
//  centered signed representative in [-(Q-1)/2, (Q-1)/2]. Used ahead of the
//  norm-check and hint stages.
//  Streaming valid/ready block with a 2-stage pipeline and full backpressure.
//  Tracks the coefficient index inside an N-coefficient polynomial and flags the
//  last beat.
// PARAMETERS
//  WIDTH  32       coefficient width, two's complement in and out
//  Q      8380417  modulus
//  N      256      coefficients per polynomial; idx_o width = $clog2(N)
//  HALFQ  (Q-1)/2  localparam, 4190208 for the default Q
// PORTS
//  clk_i    in   1          clock, rising edge
//  rst_ni   in   1          asynchronous reset, active low
//  valid_i  in   1          input coefficient valid
//  ready_o  out  1          block can accept the input this cycle
//  a_i      in   WIDTH      canonical coefficient, signed, expected 0..Q-1
//  valid_o  out  1          output coefficient valid
//  ready_i  in   1          downstream accepts the output this cycle
//  a_o      out  WIDTH      centered coefficient, signed
//  idx_o    out  $clog2(N)  index of the current output beat within its polynomial
//  last_o   out  1          valid_o && idx_o==N-1
//  clear_i  in   1          synchronous clear of err_o
//  err_o    out  1          sticky range error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release) clears:
//    - valid_o=0, a_o=0, idx_o=0, last_o=0, err_o=0
//    - every internal valid bit
//  - Reset mid-polynomial discards all in-flight beats. The next polynomial
//    starts at idx 0.
//  - Handshake:
//    - A transfer happens when valid && ready are both high on a rising edge.
//    - valid_o and a_o are held stable until ready_i is high.
//    - No combinational path from valid_i to valid_o.
//  - Stage 1 (S1):
//    - Registers a_i.
//    - Registers gt = ($signed(a_i) > HALFQ), a signed compare.
//  - Stage 2 (S2, output register):
//    - a_o = gt ? a - Q : a, computed in WIDTH bits, signed.
//  - Backpressure rules:
//    - S2 loads when S2 is empty or ready_i=1.
//    - S1 advances when S2 loads.
//    - ready_o = !S1_valid || S2_loads. This is a combinational function of
//      ready_i; the upstream side has no loop through it.
//  - Throughput and latency:
//    - 1 beat/cycle at full throughput.
//    - Latency is 2 cycles from the input handshake to valid_o when ready_i=1.
//    - At most 2 beats are in flight.
//    - No beat is lost or duplicated, and order is preserved.
//  - Simultaneous input and output handshake with both stages full: both
//    stages shift in the same cycle.
//  - Index counter:
//    - idx increments on each output handshake.
//    - On the handshake where last_o=1 it wraps to 0.
//  - Input values outside 0..Q-1 go through the same arithmetic:
//    - Negative inputs pass through unchanged.
//    - a>=Q gives a-Q.
// CONFIGURATION
//  DILI_CENTER_RANGECHK_EN
//  - Defined: each accepted input with a<0 or a>=Q sets err_o one cycle after
//    its input handshake.
//    - err_o stays set until clear_i or reset.
//    - If set and clear_i coincide, set wins.
//    - Data flow is unaffected.
//  - Undefined: err_o is tied to 0, clear_i is ignored, and no compare logic is
//    built.
// TESTING
//  1. Map values with ready_i=1, one input per cycle; each a_o is seen 2 cycles
//     after its input:
//     - in 0,1,4190208,4190209,8380416 -> a_o 0,1,4190208,-4190208,-1
//  2. Full polynomial: stream 256 beats, valid_i and ready_i held at 1:
//     - valid_o from cycle 2 on, one beat per cycle
//     - idx_o 0..255, last_o only on beat 255, idx_o back to 0 afterwards
//  3. Backpressure: drop ready_i for 3 cycles mid-stream:
//     - ready_o falls once 2 beats are held
//     - a_o stays stable while stalled
//     - after release the output sequence equals the input sequence, no
//       gaps or duplicates
//  4. Mid-polynomial reset: assert rst_ni=0 at beat 100:
//     - valid_o=0 and idx_o=0 immediately (asynchronous)
//     - the next stream starts at idx 0, with last_o on its 256th beat
//  5. Range check, macro defined:
//     - input 8380417 -> a_o=0, err_o=1 next cycle and stays 1
//     - clear_i -> err_o=0
//     - clear_i in the same cycle as a bad-input set -> err_o=1
//  6. Range check, macro undefined:
//     - inputs -5 and 8380417 -> a_o=-5 and 0
//     - err_o stays 0 throughout

Source files
------------

// File: rtl/dili_center_stream.sv
// dili_center_stream: maps canonical coefficients in [0,Q) to centered signed form, 2-stage valid/ready pipeline.
// Optional sticky range check is built when DILI_CENTER_RANGECHK_EN is defined.
module dili_center_stream #(
    parameter int WIDTH = 32,
    parameter int Q     = 8380417,
    parameter int N     = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [WIDTH-1:0] a_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [WIDTH-1:0] a_o,
    output logic [$clog2(N)-1:0]    idx_o,
    output logic                    last_o,
    input  logic                    clear_i,
    output logic                    err_o
);
    localparam int                      IDX_W    = $clog2(N);
    localparam logic signed [WIDTH-1:0] QS       = WIDTH'(Q);
    localparam logic signed [WIDTH-1:0] HALFQ    = WIDTH'((Q - 1) / 2);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N - 1);

    function automatic logic signed [WIDTH-1:0] center(input logic signed [WIDTH-1:0] a,
                                                       input logic gt);
        return gt ? a - QS : a;
    endfunction

    logic                    vld_p1;
    logic                    vld_p2;
    logic                    gt_p1;
    logic signed [WIDTH-1:0] a_p1;
    logic signed [WIDTH-1:0] a_p2;
    logic                    load_p2;
    logic                    in_fire;
    logic                    out_fire;
    logic [IDX_W-1:0]        idx;

    // S2 takes a new beat whenever it is empty or its current beat leaves this cycle.
    assign load_p2  = !vld_p2 || ready_i;
    assign ready_o  = !vld_p1 || load_p2;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = vld_p2 && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ready_o) vld_p1 <= valid_i;
            if (load_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: capture coefficient and upper-half compare ----
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            a_p1  <= a_i;
            gt_p1 <= (a_i > HALFQ);
        end
    end

    // ---- stage 2: centered output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_p2 <= '0;
        end else if (load_p2 && vld_p1) begin
            a_p2 <= center(a_p1, gt_p1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx <= '0;
        end else if (out_fire) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    assign valid_o = vld_p2;
    assign a_o     = a_p2;
    assign idx_o   = idx;
    assign last_o  = vld_p2 && (idx == IDX_LAST);

`ifdef DILI_CENTER_RANGECHK_EN
    function automatic logic out_of_range(input logic signed [WIDTH-1:0] a);
        return (a < 0) || (a >= QS);
    endfunction

    logic err;

    // A new violation outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err <= 1'b0;
        end else if (in_fire && out_of_range(a_i)) begin
            err <= 1'b1;
        end else if (clear_i) begin
            err <= 1'b0;
        end
    end

    assign err_o = err;
`else
    logic unused_clear;

    assign unused_clear = clear_i;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_dili_center_stream.sv
// tb_dili_center_stream: randomized scoreboard bench for dili_center_stream against a queue-based reference model.
module tb_dili_center_stream;
    localparam longint Q     = 8380417;
    localparam longint HALFQ = (Q - 1) / 2;
    localparam int     N     = 256;
`ifdef DILI_CENTER_RANGECHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        longint v;
        int     cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_i = 1'b0;
    logic               ready_o;
    logic signed [31:0] a_i = '0;
    logic               valid_o;
    logic               ready_i = 1'b0;
    logic signed [31:0] a_o;
    logic [7:0]         idx_o;
    logic               last_o;
    logic               clear_i = 1'b0;
    logic               err_o;

    int n_tests = 0;
    int n_fail = 0;
    int out_cnt = 0;
    int in_cnt = 0;
    int last_seen = 0;
    int cyc = 0;
    int vprob = 100;
    bit lat_chk = 1'b0;
    bit err_exp = 1'b0;
    exp_t exp_q[$];
    logic signed [31:0] src_q[$];

    dili_center_stream dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .a_o     (a_o),
        .idx_o   (idx_o),
        .last_o  (last_o),
        .clear_i (clear_i),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: values above (Q-1)/2 drop by Q, everything else passes; result wraps to 32 bits.
    function automatic longint ref_center(input longint a);
        longint             r;
        logic signed [31:0] t;
        r = (a > HALFQ) ? a - Q : a;
        t = r[31:0];
        return longint'(t);
    endfunction

    function automatic bit is_bad(input longint a);
        return (a < 0) || (a >= Q);
    endfunction

    // Monitor / scoreboard: everything sampled on the falling edge reflects the coming rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            out_cnt = 0;
            err_exp = 1'b0;
        end else begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid_o", 1, 0);
                end else begin
                    chk("a_o", longint'(a_o), exp_q[0].v);
                    chk("idx_o", idx_o, out_cnt % N);
                    chk("last_o", last_o, (out_cnt % N) == N - 1);
                    if (ready_i) begin
                        if (lat_chk) chk("latency", cyc - exp_q[0].cyc, 2);
                        if (last_o) last_seen++;
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end else begin
                chk("last_o_idle", last_o, 0);
            end
            chk("err_o", err_o, err_exp);
            if (valid_i && ready_o) begin
                chk("in_flight_le2", exp_q.size() <= 2, 1);
                exp_q.push_back('{v: ref_center(longint'(a_i)), cyc: cyc});
            end
            if (CHK && valid_i && ready_o && is_bad(longint'(a_i))) err_exp = 1'b1;
            else if (CHK && clear_i) err_exp = 1'b0;
        end
    end

    // One clock of stimulus. rmode/cmode: 0 = low, 1 = high, 2 = random.
    task automatic step(input int rmode, input int cmode);
        bit hs;
        if (!valid_i && src_q.size() > 0 && $urandom_range(99) < vprob) begin
            valid_i = 1'b1;
            a_i = src_q.pop_front();
        end
        ready_i = (rmode == 2) ? ($urandom_range(99) < 65) : (rmode == 1);
        clear_i = (cmode == 2) ? ($urandom_range(99) < 3) : (cmode == 1);
        @(negedge clk);
        hs = valid_i && ready_o;
        if (hs) in_cnt++;
        @(posedge clk);
        #1;
        if (hs) valid_i = 1'b0;
    endtask

    task automatic drain(input int rmode);
        int budget = 0;
        while ((src_q.size() > 0 || valid_i || exp_q.size() > 0) && budget < 3000) begin
            step(rmode, 0);
            budget++;
        end
        chk("drain_empty", exp_q.size() + src_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_idx_o", idx_o, 0);
        chk("rst_last_o", last_o, 0);
        chk("rst_a_o", longint'(a_o), 0);
        chk("rst_err_o", err_o, 0);
        src_q.delete();
        valid_i = 1'b0;
        clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic signed [31:0] rand_coef();
        logic signed [31:0] b[7];
        int k;
        b[0] = 0; b[1] = 1; b[2] = 32'(HALFQ); b[3] = 32'(HALFQ + 1);
        b[4] = 32'(Q - 1); b[5] = 32'sh7fffffff; b[6] = 32'sh80000000;
        k = $urandom_range(9);
        if (k <= 5) return 32'($urandom_range(32'(Q - 1), 0));
        if (k == 6) return b[$urandom_range(6)];
        if (k == 7) return -32'($urandom_range(1000000, 1));
        return 32'(Q + longint'($urandom_range(32'(HALFQ), 0)));
    endfunction

    initial begin
        int start;
        logic signed [31:0] v[5];
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int lstart;
        logic signed [31:0] hold_a;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_o", valid_o, 0);
        chk("reset_a_o", longint'(a_o), 0);
        chk("reset_idx_o", idx_o, 0);
        chk("reset_last_o", last_o, 0);
        chk("reset_err_o", err_o, 0);
        rst_n = 1'b1;

        // Mapping table, back to back with ready held high
        lat_chk = 1'b1;
        src_q = '{32'sd0, 32'sd1, 32'sd4190208, 32'sd4190209, 32'sd8380416};
        drain(1);
        lat_chk = 1'b0;

        // Out-of-range values and sticky error
        src_q = '{-32'sd5, 32'sd8380417};
        drain(1);
        src_q.push_back(32'sd8380417);
        step(1, 0);
        chk("err_set", err_o, CHK);
        step(1, 0);
        step(1, 0);
        chk("err_sticky", err_o, CHK);
        step(1, 1);
        chk("err_cleared", err_o, 0);
        src_q.push_back(32'sd8380417);
        step(1, 1);
        chk("err_set_beats_clear", err_o, CHK);
        step(1, 1);
        chk("err_cleared2", err_o, 0);
        drain(1);

        // Full polynomial at one beat per cycle
        do_reset();
        lat_chk = 1'b1;
        lstart = last_seen;
        for (int i = 0; i < N; i++) src_q.push_back(rand_coef());
        repeat (N + 2) step(1, 0);
        chk("poly_throughput", out_cnt, N);
        chk("poly_idx_wrap", idx_o, 0);
        chk("poly_last_count", last_seen - lstart, 1);
        lat_chk = 1'b0;
        drain(1);

        // Backpressure: three stalled cycles mid-stream
        for (int i = 0; i < 20; i++) src_q.push_back(rand_coef());
        repeat (8) step(1, 0);
        step(0, 0);
        hold_a = a_o;
        chk("bp_ready_low1", ready_o, 0);
        step(0, 0);
        chk("bp_ready_low2", ready_o, 0);
        chk("bp_a_stable", longint'(a_o), longint'(hold_a));
        step(0, 0);
        chk("bp_ready_low3", ready_o, 0);
        chk("bp_valid_held", valid_o, 1);
        drain(1);

        // Reset in the middle of a polynomial
        start = in_cnt;
        for (int i = 0; i < 300; i++) src_q.push_back(rand_coef());
        while (in_cnt - start < 100) step(1, 0);
        do_reset();
        lstart = last_seen;
        for (int i = 0; i < 260; i++) src_q.push_back(rand_coef());
        drain(1);
        chk("rst_poly_last_count", last_seen - lstart, 1);

        // Randomized traffic
        vprob = 70;
        for (int i = 0; i < 3000; i++) begin
            if (src_q.size() < 4) src_q.push_back(rand_coef());
            step(2, 2);
        end
        vprob = 100;
        drain(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
